// File: rtl/sparc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : sparc_control_unit
// Brief    : Multi-cycle SPARC control FSM driving datapath enables and selects,
//            with a memory-wait watchdog that halts on a stalled access.
// Revision : 1.0  initial release
// ============================================================================
module sparc_control_unit (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  input  logic        C,
  output logic        IRE,
  output logic        MDRE,
  output logic        MARE,
  output logic        PCE,
  output logic        nPCE,
  output logic        PSRE,
  output logic        RFE,
  output logic        ClrPC,
  output logic        ClrnPC,
  output logic        MFA,
  output logic [1:0]  MAR_SEL,
  output logic [1:0]  MDR_SEL,
  output logic [1:0]  nPC_SEL,
  output logic [1:0]  ALU_SEL,
  output logic [1:0]  CIN_SEL,
  output logic [1:0]  RC_SEL,
  output logic        RA_SEL,
  output logic        AOP_SEL,
  output logic        MOP_SEL,
  output logic        BAUX,
  output logic        DISP_SEL,
  output logic        nPC_ADD,
  output logic        nPC_ADDSEL,
  output logic [5:0]  OP1,
  output logic [3:0]  STATE,
  output logic        ERR
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH_A = 4'd1,
    S_FETCH_M = 4'd2,
    S_DECODE  = 4'd3,
    S_ALU     = 4'd4,
    S_EA      = 4'd5,
    S_LD_M    = 4'd6,
    S_LD_WB   = 4'd7,
    S_ST_D    = 4'd8,
    S_ST_M    = 4'd9,
    S_BR      = 4'd10,
    S_CALL    = 4'd11,
    S_UPDATE  = 4'd12,
    S_HALT    = 4'd15
  } state_t;

  localparam logic [5:0] C_OP_ADD = 6'h00;
  localparam logic [5:0] C_OP_RDW = 6'h08;
  localparam logic [5:0] C_OP_WRW = 6'h04;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_wait_cnt;
  logic        r_taken;
  logic        r_disp;
  logic        r_err;
  logic        w_base;
  logic        w_cond;
  logic        w_mem_state;
  logic        w_timeout;
  logic [1:0]  w_op;
  logic [5:0]  w_op3;
  logic        w_unused_ir;

  assign w_op        = IR[31:30];
  assign w_op3       = IR[24:19];
  assign w_unused_ir = ^{IR[29], IR[18:14], IR[12:0]};

  // Bicc: IR[28] complements the base condition selected by IR[27:25]
  always_comb begin
    w_base = 1'b0;
    case (IR[27:25])
      3'd0:    w_base = 1'b0;
      3'd1:    w_base = Z;
      3'd2:    w_base = Z | (N ^ V);
      3'd3:    w_base = N ^ V;
      3'd4:    w_base = C | Z;
      3'd5:    w_base = C;
      3'd6:    w_base = N;
      default: w_base = V;
    endcase
    w_cond = w_base ^ IR[28];
  end

  assign w_mem_state = (r_state == S_FETCH_M) || (r_state == S_LD_M) || (r_state == S_ST_M);
  assign w_timeout   = w_mem_state && !MFC && (r_wait_cnt == 4'd15);
  assign STATE       = r_state;
  assign ERR         = r_err;

  always_ff @(posedge Clk) begin
    if (!Clr) begin
      r_state    <= S_RESET;
      r_wait_cnt <= 4'd0;
      r_taken    <= 1'b0;
      r_disp     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter runs only while parked in a memory state; any transition clears it
      if (w_mem_state && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + 4'd1;
      else                                    r_wait_cnt <= 4'd0;
      if (w_timeout) r_err <= 1'b1;
      case (r_state)
        S_BR:     r_taken <= w_cond;
        S_CALL:   begin r_taken <= 1'b1; r_disp <= 1'b1; end
        S_UPDATE: begin r_taken <= 1'b0; r_disp <= 1'b0; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    IRE        = 1'b1;
    MDRE       = 1'b1;
    MARE       = 1'b1;
    PCE        = 1'b1;
    nPCE       = 1'b1;
    PSRE       = 1'b1;
    RFE        = 1'b1;
    ClrPC      = 1'b1;
    ClrnPC     = 1'b1;
    MFA        = 1'b0;
    MAR_SEL    = 2'd0;
    MDR_SEL    = 2'd0;
    nPC_SEL    = 2'd0;
    ALU_SEL    = 2'd0;
    CIN_SEL    = 2'd0;
    RC_SEL     = 2'd0;
    RA_SEL     = 1'b0;
    AOP_SEL    = 1'b0;
    MOP_SEL    = 1'b0;
    BAUX       = 1'b0;
    DISP_SEL   = 1'b0;
    nPC_ADD    = 1'b1;
    nPC_ADDSEL = 1'b0;
    OP1        = C_OP_ADD;
    case (r_state)
      S_RESET: begin
        ClrPC  = 1'b0;
        ClrnPC = 1'b0;
        w_next = S_FETCH_A;
      end
      S_FETCH_A: begin
        MAR_SEL = 2'd1;
        MARE    = 1'b0;
        w_next  = S_FETCH_M;
      end
      S_FETCH_M: begin
        MFA     = 1'b1;
        MOP_SEL = 1'b1;
        OP1     = C_OP_RDW;
        // A reset on the completing edge must not let the loads through
        if (MFC && Clr) begin
          MDRE = 1'b0;
          IRE  = 1'b0;
        end
        if (MFC)            w_next = S_DECODE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_DECODE: begin
        if (w_op == 2'b10 && w_op3[5:4] == 2'b00)                    w_next = S_ALU;
        else if (w_op == 2'b11 && (w_op3 == 6'b000000 || w_op3 == 6'b000100)) w_next = S_EA;
        else if (w_op == 2'b00 && w_op3[5:3] == 3'b010)             w_next = S_BR;
        else if (w_op == 2'b01)                                      w_next = S_CALL;
        else                                                         w_next = S_HALT;
      end
      S_ALU: begin
        ALU_SEL = {1'b0, IR[13]};
        CIN_SEL = 2'd2;
        RFE     = 1'b0;
        PSRE    = ~IR[23];
        w_next  = S_UPDATE;
      end
      S_EA: begin
        AOP_SEL = 1'b1;
        ALU_SEL = {1'b0, IR[13]};
        MARE    = 1'b0;
        w_next  = w_op3[2] ? S_ST_D : S_LD_M;
      end
      S_LD_M: begin
        MFA     = 1'b1;
        MOP_SEL = 1'b1;
        OP1     = C_OP_RDW;
        if (MFC && Clr) MDRE = 1'b0;
        if (MFC)            w_next = S_LD_WB;
        else if (w_timeout) w_next = S_HALT;
      end
      S_LD_WB: begin
        CIN_SEL = 2'd3;
        RFE     = 1'b0;
        w_next  = S_UPDATE;
      end
      S_ST_D: begin
        RA_SEL  = 1'b1;
        MDR_SEL = 2'd1;
        MDRE    = 1'b0;
        w_next  = S_ST_M;
      end
      S_ST_M: begin
        MFA     = 1'b1;
        MOP_SEL = 1'b1;
        OP1     = C_OP_WRW;
        if (MFC)            w_next = S_UPDATE;
        else if (w_timeout) w_next = S_HALT;
      end
      S_BR:   w_next = S_UPDATE;
      S_CALL: begin
        RC_SEL = 2'd3;
        RFE    = 1'b0;
        w_next = S_UPDATE;
      end
      S_UPDATE: begin
        PCE  = 1'b0;
        nPCE = 1'b0;
        if (r_taken) begin
          nPC_SEL  = 2'd2;
          BAUX     = 1'b1;
          DISP_SEL = r_disp;
        end
        w_next = S_FETCH_A;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sparc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparc_control_unit
// Brief    : Directed self-checking bench for sparc_control_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_sparc_control_unit;

  logic        clk = 1'b0;
  logic        Clr, MFC, N, Z, V, C;
  logic [31:0] IR;
  logic        IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE, ClrPC, ClrnPC, MFA;
  logic [1:0]  MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL;
  logic        RA_SEL, AOP_SEL, MOP_SEL, BAUX, DISP_SEL, nPC_ADD, nPC_ADDSEL;
  logic [5:0]  OP1;
  logic [3:0]  STATE;
  logic        ERR;
  int          checks = 0;
  int          errors = 0;

  sparc_control_unit dut (
    .Clk(clk), .Clr(Clr), .IR(IR), .MFC(MFC), .N(N), .Z(Z), .V(V), .C(C),
    .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE), .PSRE(PSRE),
    .RFE(RFE), .ClrPC(ClrPC), .ClrnPC(ClrnPC), .MFA(MFA),
    .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .nPC_SEL(nPC_SEL), .ALU_SEL(ALU_SEL),
    .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL), .RA_SEL(RA_SEL), .AOP_SEL(AOP_SEL),
    .MOP_SEL(MOP_SEL), .BAUX(BAUX), .DISP_SEL(DISP_SEL), .nPC_ADD(nPC_ADD),
    .nPC_ADDSEL(nPC_ADDSEL), .OP1(OP1), .STATE(STATE), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call in FETCH_A; returns one cycle into the dispatched state
  task automatic fetch(input logic [31:0] ir);
    IR = ir;
    tick();
    MFC = 1'b1;
    tick();
    MFC = 1'b0;
    tick();
  endtask

  task automatic set_cc(input logic [3:0] nzvc);
    {N, Z, V, C} = nzvc;
  endtask

  initial begin
    Clr = 1'b0; MFC = 1'b0; IR = 32'h0; {N, Z, V, C} = 4'b0000;
    tick(); tick();
    chk("rst_state", STATE, 4'd0);
    chk("rst_clrpc", {ClrPC, ClrnPC}, 2'b00);
    chk("rst_err", ERR, 1'b0);
    chk("rst_mfa", MFA, 1'b0);
    chk("rst_en", {IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE}, 7'h7F);

    // add r17,r17,r18: states 0,1,2,2,3,4,12,1
    Clr = 1'b1; IR = 32'hA2044012;
    tick();
    chk("add_fa_state", STATE, 4'd1);
    chk("add_fa_mar", {MAR_SEL, MARE}, 3'b010);
    tick();
    chk("add_fm_state", STATE, 4'd2);
    chk("add_fm_mem", {MFA, MOP_SEL, OP1, IRE}, {1'b1, 1'b1, 6'h08, 1'b1});
    tick();
    chk("add_fm_wait", STATE, 4'd2);
    MFC = 1'b1; #1;
    chk("add_fm_load", {IRE, MDRE}, 2'b00);
    tick(); MFC = 1'b0;
    chk("add_dec", STATE, 4'd3);
    tick();
    chk("add_alu_state", STATE, 4'd4);
    chk("add_alu_out", {RFE, CIN_SEL, PSRE, ALU_SEL, RC_SEL}, {1'b0, 2'd2, 1'b1, 2'd0, 2'd0});
    tick();
    chk("add_upd", {STATE, PCE, nPCE, nPC_SEL, RFE}, {4'd12, 1'b0, 1'b0, 2'd0, 1'b1});
    tick();
    chk("add_back_fa", STATE, 4'd1);

    // ld [r1+4],r2
    fetch(32'hC4006004);
    chk("ld_ea", {STATE, MAR_SEL, ALU_SEL, MARE, AOP_SEL, OP1}, {4'd5, 2'd0, 2'd1, 1'b0, 1'b1, 6'h00});
    tick();
    chk("ld_m", {STATE, MFA, OP1, MDRE}, {4'd6, 1'b1, 6'h08, 1'b1});
    MFC = 1'b1; #1;
    chk("ld_m_mfc", MDRE, 1'b0);
    tick(); MFC = 1'b0;
    chk("ld_wb", {STATE, CIN_SEL, RFE}, {4'd7, 2'd3, 1'b0});
    tick(); tick();
    chk("ld_back_fa", STATE, 4'd1);

    // BE taken (Z=1)
    set_cc(4'b0100);
    fetch(32'h02800004);
    chk("be_state", STATE, 4'd10);
    tick();
    chk("be_z1", {STATE, nPC_SEL, BAUX, DISP_SEL}, {4'd12, 2'd2, 1'b1, 1'b0});
    tick();
    // BE not taken (Z=0)
    set_cc(4'b0000);
    fetch(32'h02800004); tick();
    chk("be_z0", {nPC_SEL, BAUX}, {2'd0, 1'b0});
    tick();
    // BN never taken, even with every flag set
    set_cc(4'b1111);
    fetch(32'h00800004); tick();
    chk("bn", {nPC_SEL, BAUX}, {2'd0, 1'b0});
    tick();
    // BA always taken, flags clear
    set_cc(4'b0000);
    fetch(32'h10800004); tick();
    chk("ba", {nPC_SEL, BAUX}, {2'd2, 1'b1});
    tick();
    // BLE with N^V=1 taken
    set_cc(4'b1000);
    fetch(32'h04800004); tick();
    chk("ble_nv", {nPC_SEL, BAUX}, {2'd2, 1'b1});
    tick();
    // BNE with Z=1 not taken
    set_cc(4'b0100);
    fetch(32'h12800004); tick();
    chk("bne_z1", {nPC_SEL, BAUX}, {2'd0, 1'b0});
    tick();

    // CALL
    fetch(32'h40000010);
    chk("call", {STATE, RC_SEL, CIN_SEL, RFE}, {4'd11, 2'd3, 2'd0, 1'b0});
    tick();
    chk("call_upd", {STATE, DISP_SEL, nPC_SEL, BAUX}, {4'd12, 1'b1, 2'd2, 1'b1});
    tick();
    // TAKEN/DISP cleared after UPDATE
    set_cc(4'b0000);
    fetch(32'h02800004); tick();
    chk("taken_clr", {nPC_SEL, BAUX, DISP_SEL}, {2'd0, 1'b0, 1'b0});
    tick();

    // st r2,[r1+4] with no MFC -> timeout
    fetch(32'hC4206004);
    chk("st_ea", STATE, 4'd5);
    tick();
    chk("st_d", {STATE, RA_SEL, MDR_SEL, MDRE}, {4'd8, 1'b1, 2'd1, 1'b0});
    tick();
    chk("st_m", {STATE, MFA, OP1}, {4'd9, 1'b1, 6'h04});
    for (int i = 0; i < 14; i++) tick();
    chk("st_m_wait", {STATE, ERR}, {4'd9, 1'b0});
    for (int i = 0; i < 10 && STATE != 4'd15; i++) tick();
    chk("timeout_halt", {STATE, ERR}, {4'd15, 1'b1});
    chk("halt_idle", {MFA, IRE, PCE}, 3'b011);
    MFC = 1'b1; tick(); MFC = 1'b0;
    chk("halt_hold", STATE, 4'd15);
    Clr = 1'b0; tick();
    chk("halt_rst", {STATE, ERR}, {4'd0, 1'b0});

    // Illegal opcode
    Clr = 1'b1; tick();
    fetch(32'h00000000);
    chk("illegal", {STATE, ERR}, {4'd15, 1'b0});
    Clr = 1'b0; tick();
    chk("illegal_rst", STATE, 4'd0);

    // Reset dominates MFC in FETCH_M
    Clr = 1'b1; tick(); tick();
    chk("rd_fm", STATE, 4'd2);
    Clr = 1'b0; MFC = 1'b1; #1;
    chk("rd_ire_pre", IRE, 1'b1);
    tick(); MFC = 1'b0;
    chk("rd_state", {STATE, IRE, MFA}, {4'd0, 1'b1, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparc_control_unit.md
SPARC_CONTROL_UNIT -- requirements
Module: sparc_control_unit

Interface
REQ-001: Clk  input  1  sole clock; all state updates on rising edge.
REQ-002: Clr  input  1  reset; one clock, reset synchronous and active-low.
REQ-003: IR  input  32  instruction register contents from datapath.
REQ-004: MFC  input  1  memory function complete from RAM.
REQ-005: N, Z, V, C  input  1 each  PSR condition codes.
REQ-006: IRE, MDRE, MARE, PCE, nPCE, PSRE, RFE  output  1 each  active-low register load enables.
REQ-007: ClrPC, ClrnPC  output  1 each  active-low clears of PC and nPC.
REQ-008: MFA  output  1  memory function activate, active-high.
REQ-009: MAR_SEL, MDR_SEL, nPC_SEL, ALU_SEL, CIN_SEL, RC_SEL  output  2 each  datapath mux selects.
REQ-010: RA_SEL, AOP_SEL, MOP_SEL, BAUX, DISP_SEL, nPC_ADD, nPC_ADDSEL  output  1 each  datapath selects/enables.
REQ-011: OP1  output  6  ALU/memory opcode override.
REQ-012: STATE  output  4  current state code; ERR  output  1  memory-timeout flag.

Function
REQ-013: Mux encodings SHALL be:
- MAR_SEL 0=ALU, 1=PC.
- MDR_SEL 0=RAM, 1=RF_A.
- nPC_SEL 0=nPC adder, 2=branch target.
- ALU_SEL 0=RF_B, 1=simm13.
- CIN_SEL 0=PC, 2=ALU, 3=MDR.
- RC_SEL 0=rd, 3=r15.
- RA_SEL 0=rs1, 1=rd.
- AOP_SEL/MOP_SEL 0=IR[24:19], 1=OP1.
- DISP_SEL 0=disp22, 1=disp30.
REQ-014: OP1 constants SHALL be: 6'h00 ALU add, 6'h08 memory read word, 6'h04 memory write word.
REQ-015: States SHALL be: RESET=0, FETCH_A=1, FETCH_M=2, DECODE=3, ALU=4, EA=5, LD_M=6, LD_WB=7, ST_D=8, ST_M=9, BR=10, CALL=11, UPDATE=12, HALT=15.
REQ-016: Idle output values SHALL be: enables 1, MFA 0, selects 0, BAUX 0, nPC_ADD 1, nPC_ADDSEL 0 (+4), ClrPC/ClrnPC 1.
REQ-017: RESET SHALL drive ClrPC=0 and ClrnPC=0, then go to FETCH_A.
REQ-018: FETCH_A SHALL drive MAR_SEL=1 and MARE=0, then go to FETCH_M.
REQ-019: FETCH_M SHALL drive MFA=1, MOP_SEL=1, OP1=08 and MDR_SEL=0.
- On the cycle MFC=1: MDRE=0, IRE=0, next state DECODE.
- While MFC=0: remain in FETCH_M.
REQ-020: DECODE SHALL dispatch as follows:
- op=10 with op3[5:4]=00 -> ALU.
- op=11 with op3=000000 or 000100 -> EA.
- op=00 with op2=010 -> BR.
- op=01 -> CALL.
- Anything else -> HALT.
REQ-021: ALU state SHALL drive RA_SEL=0, AOP_SEL=0, ALU_SEL=IR[13], RC_SEL=0, CIN_SEL=2, RFE=0, and PSRE=IR[23] inverted (cc-setting ops load PSR); then UPDATE.
REQ-022: EA SHALL drive AOP_SEL=1, OP1=00, ALU_SEL=IR[13], MAR_SEL=0, MARE=0; then LD_M (op3[2]=0) or ST_D (op3[2]=1).
REQ-023: LD_M SHALL drive MFA=1, MOP_SEL=1, OP1=08, MDR_SEL=0, and MDRE=0 on the MFC cycle, then go to LD_WB.
REQ-024: LD_WB SHALL drive RC_SEL=0, CIN_SEL=3, RFE=0; then UPDATE.
REQ-025: ST_D SHALL drive RA_SEL=1, MDR_SEL=1, MDRE=0; then ST_M.
REQ-026: ST_M SHALL drive MFA=1, MOP_SEL=1, OP1=04; on MFC it goes to UPDATE.
REQ-027: BR SHALL evaluate cond IR[28:25] over all 16 SPARC Bicc conditions (BN, BE, BLE, BL, BLEU, BCS, BNEG, BVS, BA and their complements) and latch the result in internal TAKEN; annul bit ignored; then UPDATE.
REQ-028: CALL SHALL drive RC_SEL=3, CIN_SEL=0, RFE=0 and set TAKEN=1 with DISP latched 1; then UPDATE.
REQ-029: UPDATE SHALL drive PCE=0 and nPCE=0; then FETCH_A.
- TAKEN=1: nPC_SEL=2, BAUX=1, DISP_SEL=latched DISP.
- TAKEN=0: nPC_SEL=0.
- TAKEN and DISP SHALL clear at the end of UPDATE.
REQ-030: A 4-bit wait counter SHALL clear on entry to any memory state and count while MFC=0; at count 15 without MFC the FSM SHALL go to HALT and set ERR=1.
REQ-031: HALT SHALL hold idle outputs indefinitely; only reset exits it.
REQ-032: MFC=1 outside memory states SHALL be ignored.

Reset
REQ-033: Clr=0 at a Clk edge SHALL force the following in any state, including mid-memory-access (MFA drops next cycle):
- STATE=RESET, ERR=0, TAKEN=0, counter=0, all outputs idle.
REQ-034: Reset SHALL dominate MFC when both are asserted on the same edge.

Verification
REQ-035: Reset then MFC after 2 cycles with IR=32'hA2044012 (add r17,r17,r18) -> states 0,1,2,2,3,4,12,1; RFE=0 for one cycle with CIN_SEL=2.
REQ-036: ld [r1+4],r2 (IR=32'hC4006004), MFC replied each access -> EA drives MAR_SEL=0 and ALU_SEL=1; LD_M drives OP1=08; LD_WB drives CIN_SEL=3.
REQ-037: BE (IR=32'h02800004) branch condition checks:
- Z=1 -> UPDATE drives nPC_SEL=2, BAUX=1.
- Z=0 -> UPDATE drives nPC_SEL=0.
- BN never taken; BA always taken.
REQ-038: CALL (IR=32'h40000010) -> RC_SEL=3, CIN_SEL=0, RFE=0; then UPDATE with DISP_SEL=1, nPC_SEL=2.
REQ-039: MFC held 0 in ST_M -> HALT after 15 cycles with ERR=1; illegal IR=32'h00000000 -> HALT; Clr=0 -> RESET, ERR=0.
REQ-040: Clr=0 asserted during FETCH_M with MFC=1 on the same edge -> STATE=0, IRE stays 1.
